// File: rtl/gemm_pkg.sv
// Shared types and default sizing for the multi-tile GEMM sequencer.
// The top derives its own widths from its parameters; these are the defaults.
package gemm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    EXEC,
    DONE
  } state_t;

  localparam int GEMM_N         = 4;
  localparam int GEMM_K_MAX     = 16;
  localparam int GEMM_MAX_TILES = 4;
  localparam int GEMM_PIPE_LAT  = GEMM_N + 1;
  localparam int GEMM_ADDR_W    = 8;

  localparam int CFG_K_W    = $clog2(GEMM_K_MAX + 1);
  localparam int TILE_CNT_W = $clog2(GEMM_MAX_TILES + 1);
  localparam int PHASE_W    = $clog2(GEMM_K_MAX + GEMM_PIPE_LAT + 1);

endpackage

// File: rtl/gemm_addr_gen.sv
// Registered BRAM address and strobe generation for one sequencer position.
// Addresses only update with their strobe; a hold cycle zeroes strobes only.
module gemm_addr_gen
  import gemm_pkg::*;
#(
  parameter int N          = GEMM_N,
  parameter int PIPE_LAT   = GEMM_PIPE_LAT,
  parameter int ADDR_WIDTH = GEMM_ADDR_W,
  parameter int KW         = CFG_K_W,
  parameter int PW         = PHASE_W,
  parameter int TIW        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_hold,
  input  state_t                i_state,
  input  logic [PW-1:0]         i_phase,
  input  logic [TIW-1:0]        i_tile,
  input  logic [KW-1:0]         i_k,
  input  logic                  i_acc,
  output logic                  o_load_weights,
  output logic [ADDR_WIDTH-1:0] o_addr_b,
  output logic                  o_a_valid,
  output logic [ADDR_WIDTH-1:0] o_addr_a,
  output logic                  o_we_c,
  output logic                  o_acc_en,
  output logic [ADDR_WIDTH-1:0] o_addr_c
);

  localparam int AW = ADDR_WIDTH;

  logic          w_lw;
  logic          w_av;
  logic          w_we;
  logic          w_ae;
  logic [PW-1:0] w_r;
  logic [AW-1:0] w_ab;
  logic [AW-1:0] w_aa;
  logic [AW-1:0] w_ac;

  always_comb begin
    w_lw = 1'b0;
    w_av = 1'b0;
    w_we = 1'b0;
    w_ae = 1'b0;
    w_r  = i_phase - PW'(PIPE_LAT);
    w_ab = AW'(i_tile) * AW'(N) + AW'(i_phase);
    w_aa = AW'(i_phase);
    w_ac = i_acc ? AW'(w_r)
                 : AW'(i_tile) * AW'(i_k) + AW'(w_r);
    if (i_state == LOAD_W)
      w_lw = 1'b1;
    if (i_state == EXEC) begin
      w_av = i_phase < PW'(i_k);
      w_we = (i_phase >= PW'(PIPE_LAT)) &&
             (i_phase < PW'(i_k) + PW'(PIPE_LAT));
      // tile 0 seeds the accumulator, later K-split tiles add into it
      w_ae = w_we && i_acc && (i_tile != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_load_weights <= 1'b0;
      o_a_valid      <= 1'b0;
      o_we_c         <= 1'b0;
      o_acc_en       <= 1'b0;
      o_addr_b       <= '0;
      o_addr_a       <= '0;
      o_addr_c       <= '0;
    end else if (i_clr || i_hold) begin
      o_load_weights <= 1'b0;
      o_a_valid      <= 1'b0;
      o_we_c         <= 1'b0;
      o_acc_en       <= 1'b0;
    end else begin
      o_load_weights <= w_lw;
      o_a_valid      <= w_av;
      o_we_c         <= w_we;
      o_acc_en       <= w_ae;
      if (w_lw) o_addr_b <= w_ab;
      if (w_av) o_addr_a <= w_aa;
      if (w_we) o_addr_c <= w_ac;
    end
  end

endmodule

// File: rtl/gemm_tile_controller.sv
// Multi-tile weight-stationary GEMM sequencer: FSM, counters, stall/abort.
// Outputs are registered from the next position so they line up with it.
module gemm_tile_controller
  import gemm_pkg::*;
#(
  parameter int N          = GEMM_N,
  parameter int K_MAX      = GEMM_K_MAX,
  parameter int MAX_TILES  = GEMM_MAX_TILES,
  parameter int PIPE_LAT   = N + 1,
  parameter int ADDR_WIDTH = GEMM_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           stall,
  input  logic [$clog2(K_MAX+1)-1:0]     cfg_k,
  input  logic [$clog2(MAX_TILES+1)-1:0] cfg_tiles,
  input  logic                           cfg_acc,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           array_en,
  output logic                           load_weights,
  output logic [ADDR_WIDTH-1:0]          addr_b,
  output logic [ADDR_WIDTH-1:0]          addr_a,
  output logic                           a_valid,
  output logic                           we_c,
  output logic                           acc_en,
  output logic [ADDR_WIDTH-1:0]          addr_c,
  output logic [$clog2(MAX_TILES)-1:0]   tile_idx
);

  localparam int KW   = $clog2(K_MAX + 1);
  localparam int TCW  = $clog2(MAX_TILES + 1);
  localparam int TIW  = $clog2(MAX_TILES);
  localparam int PMAX = (N > K_MAX + PIPE_LAT) ? N : K_MAX + PIPE_LAT;
  localparam int PW   = $clog2(PMAX + 1);

  state_t         r_state;
  state_t         w_state_nx;
  logic [PW-1:0]  r_phase;
  logic [PW-1:0]  w_phase_nx;
  logic [TIW-1:0] r_tile;
  logic [TIW-1:0] w_tile_nx;
  logic [KW-1:0]  r_k;
  logic [TCW-1:0] r_tiles;
  logic           r_acc;
  logic           w_accept;
  logic           w_reject;
  logic           w_cfg_ok;
  logic           w_w_last;
  logic           w_x_last;
  logic           w_t_last;

  assign w_cfg_ok = (cfg_k != '0) && (cfg_k <= KW'(K_MAX)) &&
                    (cfg_tiles != '0) &&
                    (cfg_tiles <= TCW'(MAX_TILES));
  assign w_w_last = r_phase == PW'(N - 1);
  assign w_x_last = r_phase == PW'(r_k) + PW'(PIPE_LAT - 1);
  assign w_t_last = TCW'(r_tile) + TCW'(1) == r_tiles;

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_tile_nx  = r_tile;
    w_accept   = 1'b0;
    w_reject   = 1'b0;
    if (abort) begin
      w_state_nx = IDLE;
      w_phase_nx = '0;
      w_tile_nx  = '0;
    end else if (!stall || r_state == DONE) begin
      unique case (r_state)
        IDLE: begin
          if (start && w_cfg_ok) begin
            w_accept   = 1'b1;
            w_state_nx = LOAD_W;
            w_phase_nx = '0;
            w_tile_nx  = '0;
          end else if (start) begin
            w_reject = 1'b1;
          end
        end
        LOAD_W: begin
          if (w_w_last) begin
            w_state_nx = EXEC;
            w_phase_nx = '0;
          end else begin
            w_phase_nx = r_phase + PW'(1);
          end
        end
        EXEC: begin
          if (w_x_last) begin
            w_phase_nx = '0;
            if (w_t_last) begin
              w_state_nx = DONE;
            end else begin
              w_state_nx = LOAD_W;
              w_tile_nx  = r_tile + TIW'(1);
            end
          end else begin
            w_phase_nx = r_phase + PW'(1);
          end
        end
        DONE: w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_tile   <= '0;
      r_k      <= '0;
      r_tiles  <= '0;
      r_acc    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      array_en <= 1'b0;
      tile_idx <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_phase  <= w_phase_nx;
      r_tile   <= w_tile_nx;
      busy     <= w_state_nx != IDLE;
      done     <= w_state_nx == DONE;
      err      <= w_reject;
      array_en <= !stall;
      tile_idx <= w_tile_nx;
      if (w_accept) begin
        r_k     <= cfg_k;
        r_tiles <= cfg_tiles;
        r_acc   <= cfg_acc;
      end
    end
  end

  gemm_addr_gen #(
    .N          (N),
    .PIPE_LAT   (PIPE_LAT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .KW         (KW),
    .PW         (PW),
    .TIW        (TIW)
  ) u_addr_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clr          (abort),
    .i_hold         (stall),
    .i_state        (w_state_nx),
    .i_phase        (w_phase_nx),
    .i_tile         (w_tile_nx),
    .i_k            (r_k),
    .i_acc          (r_acc),
    .o_load_weights (load_weights),
    .o_addr_b       (addr_b),
    .o_a_valid      (a_valid),
    .o_addr_a       (addr_a),
    .o_we_c         (we_c),
    .o_acc_en       (acc_en),
    .o_addr_c       (addr_c)
  );

endmodule

// File: tb/tb_gemm_tile_controller.sv
// Directed and randomized runs against a slot-list model of the sequencer.
// Each run is expanded into expected cycles, with stall gaps inserted.
module tb_gemm_tile_controller;
  import gemm_pkg::*;

  localparam int N  = 4;
  localparam int KM = 16;
  localparam int MT = 4;
  localparam int PL = 5;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  abort;
  logic                  stall;
  logic [CFG_K_W-1:0]    cfg_k;
  logic [TILE_CNT_W-1:0] cfg_tiles;
  logic                  cfg_acc;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  array_en;
  logic                  load_weights;
  logic [7:0]            addr_b;
  logic [7:0]            addr_a;
  logic                  a_valid;
  logic                  we_c;
  logic                  acc_en;
  logic [7:0]            addr_c;
  logic [1:0]            tile_idx;

  gemm_tile_controller #(
    .N(N), .K_MAX(KM), .MAX_TILES(MT),
    .PIPE_LAT(PL), .ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .stall(stall), .cfg_k(cfg_k),
    .cfg_tiles(cfg_tiles), .cfg_acc(cfg_acc),
    .busy(busy), .done(done), .err(err),
    .array_en(array_en), .load_weights(load_weights),
    .addr_b(addr_b), .addr_a(addr_a),
    .a_valid(a_valid), .we_c(we_c), .acc_en(acc_en),
    .addr_c(addr_c), .tile_idx(tile_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit lw; int ab;
    bit av; int aa;
    bit we; bit ae; int ac;
    int tile; bit dn;
  } slot_t;

  int checks = 0;
  int errors = 0;
  int m_ab = 0;
  int m_aa = 0;
  int m_ac = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(string tag, bit bsy, bit dn, bit er,
                           bit lw, bit av, bit we, bit ae,
                           bit aen, int tile);
    chk({tag, ".strobes"},
        32'({busy, done, err, load_weights, a_valid,
             we_c, acc_en, array_en}),
        32'({bsy, dn, er, lw, av, we, ae, aen}));
    chk({tag, ".addr_b"}, 32'(addr_b), m_ab);
    chk({tag, ".addr_a"}, 32'(addr_a), m_aa);
    chk({tag, ".addr_c"}, 32'(addr_c), m_ac);
    if (tile >= 0) chk({tag, ".tile"}, 32'(tile_idx), tile);
  endtask

  task automatic chk_slot(slot_t s);
    if (s.lw) m_ab = s.ab % 256;
    if (s.av) m_aa = s.aa % 256;
    if (s.we) m_ac = s.ac % 256;
    chk_cycle("slot", 1'b1, s.dn, 1'b0, s.lw, s.av,
              s.we, s.ae, 1'b1, s.tile);
  endtask

  task automatic run(int k, int tiles, bit acc, int gslot,
                     int glen, int abslot, bit hold_start);
    slot_t s[$];
    slot_t x;
    int cyc;
    int dcyc;
    int ngap;
    cyc = 0; dcyc = 0; ngap = 0;
    for (int t = 0; t < tiles; t++) begin
      for (int i = 0; i < N; i++) begin
        x = '{1, t * N + i, 0, 0, 0, 0, 0, t, 0};
        s.push_back(x);
      end
      for (int e = 0; e < k + PL; e++) begin
        x = '{0, 0, e < k, e, 0, 0, 0, t, 0};
        if (e >= PL && e < PL + k) begin
          x.we = 1;
          x.ac = acc ? e - PL : t * k + e - PL;
          x.ae = acc && t > 0;
        end
        s.push_back(x);
      end
    end
    x = '{0, 0, 0, 0, 0, 0, 0, tiles - 1, 1};
    s.push_back(x);
    @(negedge clk);
    start = 1'b1; cfg_k = CFG_K_W'(k);
    cfg_tiles = TILE_CNT_W'(tiles); cfg_acc = acc;
    @(negedge clk);
    cyc = 1;
    if (hold_start) begin
      cfg_k = CFG_K_W'((k == 1) ? 2 : 1);
      cfg_tiles = TILE_CNT_W'(1);
      cfg_acc = ~acc;
    end else begin
      start = 1'b0;
    end
    chk_slot(s[0]);
    for (int j = 1; j < s.size(); j++) begin
      if (j == gslot) begin
        repeat (glen) begin
          stall = 1'b1;
          @(negedge clk);
          cyc++; ngap++;
          chk_cycle("stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, s[j-1].tile);
        end
      end
      stall = 1'b0;
      if (j == abslot) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_cycle("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b1, 0);
        repeat (3) begin
          @(negedge clk);
          chk("abort.nodone", 32'({busy, done}), 32'(0));
        end
        return;
      end
      @(negedge clk);
      cyc++;
      chk_slot(s[j]);
      if (s[j].dn) dcyc = cyc;
    end
    chk("done_cycle", dcyc, 1 + tiles * (N + k + PL) + ngap);
    @(negedge clk);
    start = 1'b0;
    chk_cycle("after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b1, -1);
  endtask

  task automatic reject(int k, int tiles);
    @(negedge clk);
    start = 1'b1; cfg_k = CFG_K_W'(k);
    cfg_tiles = TILE_CNT_W'(tiles); cfg_acc = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk_cycle("reject", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b1, -1);
    @(negedge clk);
    chk_cycle("reject.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b1, -1);
  endtask

  initial begin
    int k;
    int t;
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    cfg_k = '0; cfg_tiles = '0; cfg_acc = 1'b0;
    #12;
    chk_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(4, 1, 1'b0, 0, 0, -1, 1'b0);
    run(4, 2, 1'b0, 0, 0, -1, 1'b0);
    run(4, 2, 1'b1, 0, 0, -1, 1'b0);
    run(4, 2, 1'b0, N + 2, 3, -1, 1'b0);
    run(4, 1, 1'b0, 0, 0, N + 2, 1'b0);
    run(4, 1, 1'b0, 0, 0, -1, 1'b0);

    reject(0, 1);
    reject(4, 5);
    reject(17, 1);
    reject(3, 0);

    run(5, 2, 1'b1, 0, 0, -1, 1'b1);
    run(KM, MT, 1'b0, 0, 0, -1, 1'b0);
    run(1, 1, 1'b1, 0, 0, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(1, KM);
      t = $urandom_range(1, MT);
      n = t * (N + k + PL) + 1;
      run(k, t, 1'($urandom_range(0, 1)),
          $urandom_range(1, n - 1), $urandom_range(0, 3),
          -1, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    start = 1'b1; cfg_k = CFG_K_W'(8);
    cfg_tiles = TILE_CNT_W'(3); cfg_acc = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_ab = 0; m_aa = 0; m_ac = 0;
    chk_cycle("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 1, 1'b1, 2, 1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gemm_tile_controller.md
# gemm_tile_controller

Multi-tile sequencer for the N×N weight-stationary systolic GEMM array. It is the parametrised successor of the single-tile controller. Per run it loads and executes up to MAX_TILES weight tiles back-to-back with a runtime stream length, and supports two modes: independent output tiles, or K-split accumulation into one C tile. It adds stall, abort and config-error handling, and sits between the host command interface and the A/B/C BRAMs plus the array.

## Interface
- N, 4: array dimension; weight rows per tile.
- K_MAX, 16: maximum A stream length (rows) per tile.
- MAX_TILES, 4: maximum tiles per run.
- PIPE_LAT, N+1: cycles from A read address to the matching C result (BRAM plus array pipeline).
- ADDR_WIDTH, 8: BRAM address width.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  run request; sampled only in IDLE
- abort  in  1  synchronous abort; any state goes to IDLE
- stall  in  1  freeze sequencing for the current cycle
- cfg_k  in  $clog2(K_MAX+1)  A rows per tile; latched at start
- cfg_tiles  in  $clog2(MAX_TILES+1)  tile count; latched at start
- cfg_acc  in  1  1 = K-split accumulate mode; latched at start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at run completion
- err  out  1  one-cycle pulse on a rejected start
- array_en  out  1  array clock-enable, equal to !stall
- load_weights  out  1  shift weights into the array
- addr_b  out  ADDR_WIDTH  weight read address
- addr_a  out  ADDR_WIDTH  A read address
- a_valid  out  1  addr_a is valid this cycle
- we_c  out  1  C write strobe
- acc_en  out  1  C write adds to the stored value instead of overwriting
- addr_c  out  ADDR_WIDTH  C write address
- tile_idx  out  $clog2(MAX_TILES)  current tile

## Operation
- States:
  - IDLE → LOAD_W on a valid start.
  - LOAD_W: N cycles, then → EXEC.
  - EXEC: cfg_k+PIPE_LAT cycles, then → LOAD_W if more tiles remain, else → DONE.
  - DONE: one cycle, then → IDLE.
- A valid start requires 1≤cfg_k≤K_MAX and 1≤cfg_tiles≤MAX_TILES. Otherwise err pulses next cycle and the state stays IDLE.
- LOAD_W cycle i (0..N-1): load_weights=1, addr_b = tile_idx*N + i.
- EXEC cycle e:
  - For e<cfg_k: a_valid=1, addr_a=e.
  - For PIPE_LAT ≤ e < PIPE_LAT+cfg_k: we_c=1, with r = e−PIPE_LAT.
- C addressing when cfg_acc=0: addr_c = tile_idx*cfg_k + r; acc_en=0.
- C addressing when cfg_acc=1: addr_c = r; acc_en=1 for tile_idx>0 and 0 for tile 0 (tile 0 overwrites).
- Address arithmetic is modulo 2^ADDR_WIDTH, with no overflow error.
- Strobes not listed for a state are 0. addr_* hold their last value when their strobe is low.
- stall=1: state, counters and tile_idx freeze. load_weights, a_valid and we_c are forced 0 that cycle. Sequencing resumes exactly where it stopped.
- abort=1: next cycle the state is IDLE and all strobes are 0. done is not pulsed. abort has priority over stall and over start.
- start while busy is ignored.
- Reset values: all outputs 0, state IDLE, counters 0.

## Timing
- All outputs are registered. start sampled high at edge t0 gives first LOAD_W outputs in cycle t0+1.
- Tile length is N + cfg_k + PIPE_LAT unstalled cycles. done is high in cycle t0+1+cfg_tiles*(N+cfg_k+PIPE_LAT), plus one cycle per stalled cycle.
- busy rises in the first LOAD_W cycle and falls the cycle after done.
- A start in the same cycle as done is ignored. A new start is accepted from the first IDLE cycle.
- Tile boundary: the last EXEC cycle of tile t is followed directly by LOAD_W of tile t+1, with no idle gap. tile_idx increments on that transition.

## Structure
- Package gemm_pkg holds: the state enum (IDLE, LOAD_W, EXEC, DONE); width localparams for the cfg_k, tile and phase counters; and the default PIPE_LAT.
- One natural sub-module, gemm_addr_gen: combinational/registered address and strobe generation from (state, phase counter, tile_idx, latched config). The FSM, counters, stall and abort stay in the top.

## Test plan
- N=4, PIPE_LAT=5, cfg_k=4, cfg_tiles=1, cfg_acc=0:
  - addr_b 0..3 in cycles 1–4.
  - addr_a 0..3 in cycles 5–8.
  - we_c with addr_c 0..3 in cycles 10–13.
  - done at cycle 14.
- cfg_tiles=2, cfg_k=4, cfg_acc=0:
  - tile 1 addr_b 4..7 starting at cycle 14.
  - addr_c 4..7 with acc_en=0.
  - done at cycle 27.
- Same run with cfg_acc=1:
  - tile 1 writes addr_c 0..3 with acc_en=1.
  - tile 0 writes with acc_en=0.
- stall held for 3 cycles mid-EXEC: strobes are 0 during the stall, the address sequence is unbroken, and done is delayed by exactly 3 cycles.
- abort in EXEC cycle 2: IDLE next cycle, busy=0, no done pulse, and a subsequent start runs normally.
- Rejected starts: start with cfg_k=0, cfg_tiles=5, or cfg_k=17 → err pulse, busy stays 0. start while busy → ignored. rst_n asserted mid-run → all outputs 0 immediately.
